// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with runtime-loadable pattern and overlap select.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt counter and its port.
module seq_detector_param #(
  parameter int                PAT_W   = 3,
  parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(3'b101),
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              seq_in,
  input  logic              mode_ovl,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              cnt_clr,
`ifdef SEQ_DET_CNT_EN
  output logic              det_o,
  output logic [CNT_W-1:0]  match_cnt
`else
  output logic              det_o
`endif
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  logic [PAT_W-1:0] pat_r, hist, hist_sh, pat_n, hist_n;
  logic [FW-1:0]    fill, fill_inc, fill_n;
  logic             acc, match;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r <= PAT_RST;
      hist  <= '0;
      fill  <= '0;
      det_o <= 1'b0;
    end else begin
      pat_r <= pat_n;
      hist  <= hist_n;
      fill  <= fill_n;
      det_o <= match;
    end
  end
  // fill gating keeps the zeroed history from matching an all-zeros pattern
  always_comb begin
    hist_sh  = {hist[PAT_W-2:0], seq_in};
    fill_inc = (fill == FULL) ? fill : fill + 1'b1;
    acc      = in_valid && !pat_load;
    match    = acc && (fill_inc == FULL) && (hist_sh == pat_r);
    pat_n    = pat_load ? pat_in : pat_r;
    hist_n   = pat_load ? '0 : acc ? hist_sh : hist;
    fill_n   = pat_load ? '0 : !acc ? fill : (match && !mode_ovl) ? '0 : fill_inc;
  end
`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_cnt <= '0;
    else
      match_cnt <= cnt_clr ? '0 : (match && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
  end
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven directed checks of seq_detector_param (PAT_W=3 defaults).
module tb_seq_detector_param;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, seq_in = 1'b0, mode_ovl = 1'b1;
  logic pat_load = 1'b0, cnt_clr = 1'b0, det_o;
  logic [2:0] pat_in = 3'b000;
  int n_chk = 0, n_fail = 0;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] match_cnt;
`endif
  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .seq_in(seq_in), .mode_ovl(mode_ovl),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_CNT_EN
    .match_cnt(match_cnt),
`endif
    .det_o(det_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rst_v, vld, bit_v, ovl, ld;
    logic [2:0] pat;
    logic       exp_det;
    string      name;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic v, input logic b, input logic o, input logic l,
                     input logic [2:0] p, input logic e, input string n);
    vec_t t;
    t.rst_v = r; t.vld = v; t.bit_v = b; t.ovl = o; t.ld = l; t.pat = p; t.exp_det = e; t.name = n;
    vecs.push_back(t);
  endtask
  task automatic acc(input logic b, input logic o, input logic e, input string n);
    add(1, 1, b, o, 0, 3'b000, e, n);
  endtask
  task automatic idle(input logic e, input string n);
    add(1, 0, 0, 1, 0, 3'b000, e, n);
  endtask
  task automatic load(input logic [2:0] p, input string n);
    add(1, 1, 1, 1, 1, p, 0, n);
  endtask
  task automatic drive(input logic v, input logic b, input logic c);
    in_valid = v; seq_in = b; cnt_clr = c; pat_load = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    add(0, 0, 0, 1, 0, 3'b000, 0, "reset");
    acc(1, 1, 0, "t1_b1"); acc(0, 1, 0, "t1_b2"); acc(1, 1, 1, "t1_b3");
    acc(0, 1, 0, "t1_b4"); acc(1, 1, 1, "t1_b5"); idle(0, "t1_idle");
    load(3'b101, "t2_clr");
    acc(1, 0, 0, "t2_b1"); acc(0, 0, 0, "t2_b2"); acc(1, 0, 1, "t2_b3"); acc(0, 0, 0, "t2_b4");
    acc(1, 0, 0, "t2_b5"); acc(0, 0, 0, "t2_b6"); acc(1, 0, 1, "t2_b7");
    load(3'b101, "t3_clr");
    acc(1, 1, 0, "t3_b1");
    for (int i = 0; i < 4; i++) idle(0, "t3_gap1");
    acc(0, 1, 0, "t3_b2");
    for (int i = 0; i < 4; i++) idle(0, "t3_gap2");
    acc(1, 1, 1, "t3_b3"); idle(0, "t3_after");
    load(3'b101, "t4_clr");
    acc(1, 1, 0, "t4_b1"); acc(0, 1, 0, "t4_b2");
    add(0, 1, 1, 1, 0, 3'b000, 0, "t4_rst");
    acc(1, 1, 0, "t4_post1"); acc(0, 1, 0, "t4_post2"); acc(1, 1, 1, "t4_post3");
    load(3'b110, "t5_load_drop");
    acc(1, 1, 0, "t5_b1"); acc(1, 1, 0, "t5_b2"); acc(0, 1, 1, "t5_b3");
    load(3'b110, "t5_clr");
    acc(1, 1, 0, "t5_old1"); acc(0, 1, 0, "t5_old2"); acc(1, 1, 0, "t5_old3");
    load(3'b000, "zero_load");
    acc(0, 1, 0, "zero_b1"); acc(0, 1, 0, "zero_b2"); acc(0, 1, 1, "zero_b3"); acc(0, 1, 1, "zero_b4");
    acc(0, 0, 1, "zero_ovl_off"); acc(0, 0, 0, "zero_no1"); acc(0, 0, 0, "zero_no2");
    acc(0, 0, 1, "zero_again");
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst_v; in_valid = vecs[i].vld; seq_in = vecs[i].bit_v;
      mode_ovl = vecs[i].ovl; pat_load = vecs[i].ld; pat_in = vecs[i].pat;
      @(posedge clk); #1;
      check(vecs[i].name, {31'd0, det_o}, {31'd0, vecs[i].exp_det});
    end
    rst = 1'b1;
    pat_load = 1'b1; pat_in = 3'b101; @(posedge clk); #1;
    mode_ovl = 1'b0;
    drive(1, 1, 0);
    repeat (20) drive(0, 0, 0);
    drive(1, 0, 0);
    repeat (20) drive(0, 0, 0);
    check("long_gap_idle", {31'd0, det_o}, 32'd0);
    drive(1, 1, 0);
    check("long_gap_match", {31'd0, det_o}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_rst", {31'd0, det_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
`ifdef SEQ_DET_CNT_EN
    check("cnt_reset", {24'd0, match_cnt}, 32'd0);
    mode_ovl = 1'b1;
    drive(1, 1, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 0);
      drive(1, 1, 0);
    end
    check("cnt_sat", {24'd0, match_cnt}, 32'd255);
    drive(1, 0, 0);
    drive(1, 1, 1);
    check("cnt_clr_win", {24'd0, match_cnt}, 32'd0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    check("cnt_after_clr", {24'd0, match_cnt}, 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the generalised successor to the fixed 3-bit "101" FSM detector. It compares a qualified serial bit stream against a runtime-loadable PAT_W-bit pattern, with selectable overlapping or non-overlapping detection. It produces a registered one-cycle detect pulse and, optionally, a saturating match counter. It sits on serial receive paths (framing and sync-word search) downstream of a bit-valid source.

Parameters:
PAT_W, 3, pattern length in bits; legal range 2..32.
PAT_RST, 3'b101 (PAT_W bits), pattern-register value after reset; MSB is the oldest bit.
CNT_W, 8, match-counter width (used only with SEQ_DET_CNT_EN).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted; release is synchronous to clk by upstream).
in_valid  input  1  seq_in is accepted on this rising edge only when in_valid=1.
seq_in  input  1  serial data bit.
mode_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
pat_load  input  1  load pat_in into the pattern register.
pat_in  input  PAT_W  new pattern; MSB is compared against the oldest bit.
cnt_clr  input  1  synchronous clear of match_cnt.
det_o  output  1  registered detect pulse.
match_cnt  output  CNT_W  saturating match count (port present only with SEQ_DET_CNT_EN).

Behaviour:
- State registers:
  - pat_r[PAT_W-1:0]
  - hist[PAT_W-1:0]: last accepted bits, newest at LSB.
  - fill: 0..PAT_W, saturating; counts accepted bits since the last clear.
  - det_o.
- Reset (rst=0, asynchronous): pat_r=PAT_RST, hist=0, fill=0, det_o=0, match_cnt=0. A reset mid-stream discards partial history; no detect can be formed from pre-reset bits.
- Accept (in_valid=1, pat_load=0):
  - hist_n = {hist[PAT_W-2:0], seq_in}
  - fill_n = min(fill+1, PAT_W)
  - match = (fill_n == PAT_W) && (hist_n == pat_r)
- det_o timing:
  - det_o <= match on every edge; det_o <= 0 on any edge with no accept.
  - Latency: det_o is high in the cycle after the edge that accepts the final pattern bit. It is high for exactly one cycle per match; back-to-back matches give consecutive high cycles.
- Gaps: in_valid=0 cycles hold hist and fill. Gaps of any length do not break a partial match.
- Overlap mode (mode_ovl=1): fill unchanged on a match, so a pattern suffix can seed the next match.
- Non-overlap mode (mode_ovl=0): on a match, fill <= 0 (hist still shifts). The next match needs PAT_W fresh accepted bits.
- mode_ovl change: sampled on each accept. It is not a clear and takes effect from the next accepted bit.
- pat_load=1 (priority over accept): pat_r <= pat_in, hist <= 0, fill <= 0, det_o <= 0. A bit presented in the same cycle is dropped.
- The pattern all-zeros is legal; fill gating prevents a false match from reset-state hist.
- No combinational path from inputs to outputs.

Optional Feature:
Macro SEQ_DET_CNT_EN.
- Defined:
  - match_cnt port and register exist; increment by 1 on each edge where match=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets the counter to 0 and wins over a simultaneous increment.
  - pat_load does not clear the counter.
- Not defined: no counter logic and no match_cnt port. cnt_clr is still a port but is ignored.

Test Plan:
1. Defaults, mode_ovl=1, in_valid=1 every cycle, stream 1,0,1,0,1 -> det_o high in the cycle after bit 3 and the cycle after bit 5. With counter enabled, match_cnt=2.
2. Same stream, mode_ovl=0 -> det_o only after bit 3. Stream 1,0,1,0,1,0,1 -> det_o after bits 3 and 7 only.
3. Bits 1,0,1 with 4 idle in_valid=0 cycles between each -> single det_o pulse one cycle after the third accepted bit; det_o low during all gaps.
4. Accept 1,0, then drive rst=0 for 1 cycle, release, accept 1 -> no det_o. Then accept 0,1 -> det_o pulses (full fresh 1,0,1).
5. pat_load=1 with pat_in=3'b110 while seq_in=1 and in_valid=1 -> that bit is dropped. Then stream 1,1,0 -> det_o pulse. The old pattern 1,0,1 no longer detects.
6. SEQ_DET_CNT_EN, CNT_W=8, 300 overlapping matches -> match_cnt holds 255. cnt_clr asserted on a match edge -> match_cnt=0 next cycle, then 1 after the following match.
